// File: rtl/udc_seg_scan_if.sv
// Display-side bundle for udc_seg_scan: the counter's level outputs in,
// the multiplexed common-anode drive out.
interface udc_seg_scan_if;
  logic [3:0] value;  // count from the up/down counter, 0..15
  logic       up;     // 1 = counting up, 0 = counting down
  logic [6:0] seg;    // active-low segments, seg[0]=a .. seg[6]=g
  logic       dp;     // active-low decimal point
  logic [3:0] an;     // active-low digit enables

  // Display driver side.
  modport slave (
    input  value,
    input  up,
    output seg,
    output dp,
    output an
  );

  // Counter / board side.
  modport master (
    output value,
    output up,
    input  seg,
    input  dp,
    input  an
  );
endinterface

// File: rtl/udc_seg_scan.sv
// Four-digit multiplexed seven-segment driver for the up/down counter.
// Digit 0 shows the units of the count, digit 1 the tens ('1' or blank),
// digit 2 is always blank and digit 3 shows 'U' or 'd' for the direction.
// value/up are sampled once per frame so a digit never changes mid-frame,
// and every slot opens with BLANK cycles of all digits off so the segment
// bus can settle before the next digit is enabled.
module udc_seg_scan #(
  parameter int SCAN_DIV = 50000,  // clock cycles per digit slot
  parameter int BLANK    = 2       // all-off cycles at the start of each slot
) (
  input  logic          clk,
  input  logic          reset,     // asynchronous, active-low
  udc_seg_scan_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_W  = DIV_W'(BLANK);

  // Reject parameter sets that leave no lit cycles in a slot.
  if (SCAN_DIV < BLANK + 2) begin : g_bad_scan_div
    $error("udc_seg_scan: SCAN_DIV must be at least BLANK+2");
  end
  if (BLANK < 0) begin : g_bad_blank
    $error("udc_seg_scan: BLANK must be non-negative");
  end

  // Glyphs the display can show; the digit values double as their codes.
  typedef enum logic [3:0] {
    G_0     = 4'd0,
    G_1     = 4'd1,
    G_2     = 4'd2,
    G_3     = 4'd3,
    G_4     = 4'd4,
    G_5     = 4'd5,
    G_6     = 4'd6,
    G_7     = 4'd7,
    G_8     = 4'd8,
    G_9     = 4'd9,
    G_U     = 4'd10,
    G_D     = 4'd11,
    G_BLANK = 4'd15
  } glyph_e;

  // Active-low segment patterns, bit order g..a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan state and the per-frame snapshot of the counter.
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       val_s;
  logic             up_s;

  // Registered outputs.
  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic             dp_q;

  // Decode of the current slot position.
  logic             tick;
  logic             frame_end;
  logic             blank_win;
  logic [3:0]       units;
  logic             has_tens;
  glyph_e           glyph;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;

  assign tick      = (div == DIV_LAST);
  assign frame_end = tick && (idx == 2'd3);
  assign blank_win = (div < BLANK_W);

  // Split the 0..15 snapshot into a units digit and a tens flag.
  assign has_tens = (val_s >= 4'd10);
  assign units    = has_tens ? (val_s - 4'd10) : val_s;

  // Slot divider and digit index: idx advances on the last cycle of a slot.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Capture value/up once per frame, on the edge that closes slot 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_s <= 4'd0;
      up_s  <= 1'b1;
    end else if (frame_end) begin
      val_s <= bus.value;
      up_s  <= bus.up;
    end
  end

  // Choose which glyph belongs to the digit currently being scanned.
  // NOTE: the default is assigned before the case so every path writes glyph
  // and no latch is inferred.
  always_comb begin
    glyph = G_BLANK;
    case (idx)
      2'd0:    glyph = glyph_e'(units);
      2'd1:    glyph = has_tens ? G_1 : G_BLANK;
      2'd2:    glyph = G_BLANK;
      default: glyph = up_s ? G_U : G_D;
    endcase
  end

  // Translate the glyph to its active-low segment pattern.
  always_comb begin
    seg_next = SEG_BLANK;
    case (glyph)
      G_0:     seg_next = SEG_0;
      G_1:     seg_next = SEG_1;
      G_2:     seg_next = SEG_2;
      G_3:     seg_next = SEG_3;
      G_4:     seg_next = SEG_4;
      G_5:     seg_next = SEG_5;
      G_6:     seg_next = SEG_6;
      G_7:     seg_next = SEG_7;
      G_8:     seg_next = SEG_8;
      G_9:     seg_next = SEG_9;
      G_U:     seg_next = SEG_U;
      G_D:     seg_next = SEG_D;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // Enable the scanned digit only once the slot's blank window has elapsed.
  always_comb begin
    an_next = 4'b1111;
    if (!blank_win) begin
      an_next = ~(4'b0001 << idx);
    end
  end

  // Register the drive so the pins are glitch-free and one cycle behind div/idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      dp_q  <= 1'b1;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
